// File: rtl/inter.sv
// Resolved bus: a weak register under two per-bit strong drivers.
// Strong drivers that disagree leave the bit at its previous value and flag a conflict.
module inter #(
    parameter int unsigned         W         = 15,
    parameter int unsigned         TAP       = W - 5,
    parameter logic [W-1:0]        WEAK_INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         weak_load,
    input  logic [W-1:0] weak_val,
    input  logic [W-1:0] sa_en,
    input  logic [W-1:0] sa_val,
    input  logic [W-1:0] sb_en,
    input  logic [W-1:0] sb_val,
    output logic [W-1:0] bus,
    output logic         a,
    output logic         a_rise,
    output logic [W-1:0] conflict,
    output logic         conflict_any
);

    logic [W-1:0] weak_q, weak_d;
    logic [W-1:0] bus_q, bus_d;
    logic [W-1:0] conf_q, conf_d;
    logic         rise_q, rise_d;

    logic [W-1:0] any_en;
    logic [W-1:0] strong_v;

    // Per-bit resolution against the current weak register content
    always_comb begin
        any_en   = sa_en | sb_en;
        strong_v = (sa_en & sa_val) | (sb_en & sb_val);
        conf_d   = sa_en & sb_en & (sa_val ^ sb_val);
        bus_d    = (conf_d & bus_q)
                 | (~conf_d & any_en & strong_v)
                 | (~any_en & weak_q);
        weak_d   = weak_load ? weak_val : weak_q;
        rise_d   = bus_d[TAP] & ~bus_q[TAP];
    end

    // State update; bus_q[TAP] also serves as the history of a
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weak_q <= WEAK_INIT;
            bus_q  <= WEAK_INIT;
            conf_q <= '0;
            rise_q <= 1'b0;
        end else begin
            weak_q <= weak_d;
            bus_q  <= bus_d;
            conf_q <= conf_d;
            rise_q <= rise_d;
        end
    end

    assign bus          = bus_q;
    assign a            = bus_q[TAP];
    assign a_rise       = rise_q;
    assign conflict     = conf_q;
    assign conflict_any = |conf_q;

endmodule

// File: tb/tb_inter.sv
// Directed bench for inter with default parameters (W=15, TAP=10).
// Outputs are sampled 1 time unit after each rising edge.
module tb_inter;

    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         weak_load;
    logic [W-1:0] weak_val;
    logic [W-1:0] sa_en, sa_val, sb_en, sb_val;
    logic [W-1:0] bus;
    logic         a, a_rise;
    logic [W-1:0] conflict;
    logic         conflict_any;

    int checks = 0;
    int errors = 0;

    inter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .weak_load    (weak_load),
        .weak_val     (weak_val),
        .sa_en        (sa_en),
        .sa_val       (sa_val),
        .sb_en        (sb_en),
        .sb_val       (sb_val),
        .bus          (bus),
        .a            (a),
        .a_rise       (a_rise),
        .conflict     (conflict),
        .conflict_any (conflict_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] ae, input logic [W-1:0] av,
                         input logic [W-1:0] be, input logic [W-1:0] bv);
        sa_en  = ae;
        sa_val = av;
        sb_en  = be;
        sb_val = bv;
    endtask

    initial begin
        rst_n     = 1'b0;
        weak_load = 1'b0;
        weak_val  = '0;
        drive('0, '0, '0, '0);
        #12;
        chk("rst_bus", 64'(bus), 64'h0);
        chk("rst_a", 64'(a), 64'h0);
        chk("rst_rise", 64'(a_rise), 64'h0);
        chk("rst_cany", 64'(conflict_any), 64'h0);
        chk("rst_conf", 64'(conflict), 64'h0);
        rst_n = 1'b1;
        step();
        chk("idle_bus", 64'(bus), 64'h0);

        drive(15'h7FFF, 15'h7FFF, '0, '0);
        step();
        chk("sa_bus", 64'(bus), 64'h7FFF);
        chk("sa_a", 64'(a), 64'h1);
        chk("sa_rise", 64'(a_rise), 64'h1);
        step();
        chk("sa_rise2", 64'(a_rise), 64'h0);
        chk("sa_bus2", 64'(bus), 64'h7FFF);

        drive('0, '0, '0, '0);
        step();
        chk("rel_bus", 64'(bus), 64'h0);
        chk("rel_a", 64'(a), 64'h0);
        chk("rel_rise", 64'(a_rise), 64'h0);

        weak_load = 1'b1;
        weak_val  = 15'h0400;
        step();
        weak_load = 1'b0;
        chk("wk_edge1", 64'(bus), 64'h0);
        step();
        chk("wk_edge2", 64'(bus), 64'h0400);
        chk("wk_a", 64'(a), 64'h1);
        chk("wk_rise", 64'(a_rise), 64'h1);

        weak_load = 1'b1;
        weak_val  = 15'h0000;
        step();
        weak_load = 1'b0;
        step();
        chk("wk0_bus", 64'(bus), 64'h0);

        drive(15'h0403, 15'h0401, 15'h0406, 15'h0004);
        step();
        chk("cf_bus", 64'(bus), 64'h0005);
        chk("cf_conf", 64'(conflict), 64'h0400);
        chk("cf_any", 64'(conflict_any), 64'h1);
        chk("cf_a", 64'(a), 64'h0);

        sb_val = 15'h0404;
        step();
        chk("eq_bus", 64'(bus), 64'h0405);
        chk("eq_conf", 64'(conflict), 64'h0);
        chk("eq_any", 64'(conflict_any), 64'h0);
        chk("eq_a", 64'(a), 64'h1);
        chk("eq_rise", 64'(a_rise), 64'h1);

        sb_val = 15'h0004;
        step();
        chk("hold1_bus", 64'(bus), 64'h0405);
        chk("hold1_conf", 64'(conflict), 64'h0400);
        chk("hold1_rise", 64'(a_rise), 64'h0);

        drive('0, '0, 15'h0001, '0);
        weak_load = 1'b1;
        weak_val  = 15'h7000;
        step();
        weak_load = 1'b0;
        chk("both_bus", 64'(bus), 64'h0000);
        chk("both_any", 64'(conflict_any), 64'h0);
        drive('0, '0, '0, '0);
        step();
        chk("both_bus2", 64'(bus), 64'h7000);
        chk("both_a", 64'(a), 64'h0);

        drive(15'h7FFF, 15'h7FFF, '0, '0);
        step();
        chk("pre_rst_bus", 64'(bus), 64'h7FFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bus", 64'(bus), 64'h0);
        chk("arst_a", 64'(a), 64'h0);
        chk("arst_rise", 64'(a_rise), 64'h0);
        drive('0, '0, '0, '0);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_weak", 64'(bus), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
